// File: rtl/period_meter.sv
// period_meter: measures the spacing, in clk cycles, between successive
// ce_in pulses. Reports each new period with a one-cycle valid strobe,
// flags lock after LOCK_N identical periods, and raises a sticky timeout
// when no pulse arrives within TIMEOUT cycles.
module period_meter #(
  parameter int W       = 16,
  parameter int TIMEOUT = 1000,
  parameter int LOCK_N  = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce_in,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         locked,
  output logic         timeout
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  localparam logic [W-1:0] C_TIMEOUT = W'(TIMEOUT);
  localparam logic [W-1:0] C_ONE     = W'(1);
  localparam logic [3:0]   C_LOCK_N  = 4'(LOCK_N);

  state_t       r_state, w_state_next;
  logic [W-1:0] r_cnt, w_cnt_next;
  logic [W-1:0] r_period, w_period_next;
  logic [3:0]   r_match, w_match_next;
  logic         r_valid, w_valid_next;
  logic         r_locked, w_locked_next;
  logic         r_timeout, w_timeout_next;

  // Match count for a measurement finishing this edge. A zero match means
  // no measurement has been taken since reset or the last timeout, so the
  // stored period is stale and must not be compared against.
  logic [3:0] w_match_new;
  always_comb begin
    w_match_new = 4'd1;
    if (r_match != 4'd0 && r_cnt == r_period) begin
      w_match_new = (r_match == C_LOCK_N) ? C_LOCK_N : r_match + 4'd1;
    end
  end

  // Next-state and datapath update; everything holds unless changed.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_period_next  = r_period;
    w_match_next   = r_match;
    w_valid_next   = 1'b0;
    w_locked_next  = r_locked;
    w_timeout_next = r_timeout;
    case (r_state)
      S_IDLE: begin
        // The first pulse only arms the counter; there is nothing to report.
        if (ce_in) begin
          w_state_next = S_MEASURE;
          w_cnt_next   = C_ONE;
        end
      end
      S_MEASURE: begin
        if (ce_in) begin
          // A pulse landing exactly at TIMEOUT is still a valid measurement.
          w_period_next  = r_cnt;
          w_valid_next   = 1'b1;
          w_cnt_next     = C_ONE;
          w_timeout_next = 1'b0;
          w_match_next   = w_match_new;
          w_locked_next  = (w_match_new == C_LOCK_N);
        end else if (r_cnt == C_TIMEOUT) begin
          // Signal lost: drop lock, keep the last period for inspection.
          w_state_next   = S_IDLE;
          w_cnt_next     = '0;
          w_timeout_next = 1'b1;
          w_locked_next  = 1'b0;
          w_match_next   = 4'd0;
        end else begin
          // Cannot wrap: the timeout branch caps cnt at TIMEOUT <= 2^W-1.
          w_cnt_next = r_cnt + C_ONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register; reset wins over any pulse arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_match   <= 4'd0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_period  <= w_period_next;
      r_match   <= w_match_next;
      r_valid   <= w_valid_next;
      r_locked  <= w_locked_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign period  = r_period;
  assign valid   = r_valid;
  assign locked  = r_locked;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_period_meter.sv
// Testbench for period_meter: directed scenarios plus random pulse spacing,
// checked against an event-level model that tracks pulse timestamps.
module tb_period_meter;

  localparam int W  = 16;
  localparam int TO = 50;
  localparam int LN = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ce_in = 1'b0;
  logic [W-1:0] period;
  logic         valid;
  logic         locked;
  logic         timeout;

  period_meter #(.W(W), .TIMEOUT(TO), .LOCK_N(LN)) dut (
    .clk     (clk),
    .rst     (rst),
    .ce_in   (ce_in),
    .period  (period),
    .valid   (valid),
    .locked  (locked),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: timestamps of pulses and the list of measured gaps.
  int           t = 0;
  int           m_last = 0;
  bit           m_armed = 0;
  int           hist[$];
  logic [W-1:0] m_period = '0;
  bit           m_valid = 0;
  bit           m_locked = 0;
  bit           m_timeout = 0;

  function automatic bit tail_equal(input int v);
    if (hist.size() < LN) return 0;
    for (int i = hist.size() - LN; i < hist.size(); i++)
      if (hist[i] != v) return 0;
    return 1;
  endfunction

  task automatic model_edge(input bit c, input bit r);
    int gap;
    t++;
    m_valid = 0;
    if (r) begin
      m_armed = 0; hist.delete(); m_period = '0; m_locked = 0; m_timeout = 0;
    end else if (!m_armed) begin
      if (c) begin m_armed = 1; m_last = t; end
    end else begin
      gap = t - m_last;
      if (c) begin
        m_period = W'(gap); m_valid = 1; m_timeout = 0;
        hist.push_back(gap); m_last = t;
        m_locked = tail_equal(gap);
      end else if (gap >= TO) begin
        m_armed = 0; m_timeout = 1; m_locked = 0; hist.delete();
      end
    end
  endtask

  function automatic string got_s();
    return $sformatf("p=%0d v=%0b l=%0b to=%0b", period, valid, locked, timeout);
  endfunction

  function automatic string want_s();
    return $sformatf("p=%0d v=%0b l=%0b to=%0b", m_period, m_valid, m_locked, m_timeout);
  endfunction

  // Drive one clock edge worth of inputs, advance the model, sample after.
  task automatic step(input bit c, input bit r);
    @(negedge clk);
    ce_in = c;
    rst   = r;
    @(posedge clk);
    model_edge(c, r);
    #1;
    if (valid === 1'b1)
      $display("tx t=%0d period=%0d locked=%0b timeout=%0b", t, period, locked, timeout);
  endtask

  task automatic test_reset();
    step(1, 1);
    step(1'($urandom_range(0, 1)), 1);
    n_cmp++;
    if ({period, valid, locked, timeout} !== {(W+3){1'b0}}) begin
      n_bad++; $display("FAIL reset_zero t=%0d got %s want all zero", t, got_s());
    end
    n_cmp++;
    if ({period, valid, locked, timeout} !== {m_period, m_valid, m_locked, m_timeout}) begin
      n_bad++; $display("FAIL reset_model t=%0d got %s want %s", t, got_s(), want_s());
    end
  endtask

  task automatic test_steady12();
    int nv = 0;
    for (int i = 0; i <= 72; i++) begin
      step((i % 12) == 0, 0);
      n_cmp++;
      if ({period, valid, locked, timeout} !== {m_period, m_valid, m_locked, m_timeout}) begin
        n_bad++; $display("FAIL steady12 t=%0d got %s want %s", t, got_s(), want_s());
      end
      if (valid === 1'b1) begin
        nv++;
        n_cmp++;
        if (period !== 16'd12 || timeout !== 1'b0 || locked !== (nv >= 3)) begin
          n_bad++; $display("FAIL steady12_valid n=%0d got %s want p=12 l=%0b to=0", nv, got_s(), nv >= 3);
        end
      end
    end
    n_cmp++;
    if (nv != 6) begin
      n_bad++; $display("FAIL steady12_count got %0d valids want 6", nv);
    end
  endtask

  task automatic test_const_high();
    step(0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 0);
      n_cmp++;
      if ({period, valid, locked, timeout} !== {m_period, m_valid, m_locked, m_timeout}) begin
        n_bad++; $display("FAIL const_high t=%0d got %s want %s", t, got_s(), want_s());
      end
      n_cmp++;
      if (i == 0 ? (valid !== 1'b0)
                 : (valid !== 1'b1 || period !== 16'd1 || locked !== (i >= 3))) begin
        n_bad++; $display("FAIL const_high_rule i=%0d got %s want v=%0b p=1 l=%0b", i, got_s(), i != 0, i >= 3);
      end
    end
  endtask

  task automatic test_timeout();
    step(0, 1);
    for (int i = 0; i <= 24; i++) begin
      step((i % 12) == 0, 0);
      n_cmp++;
      if ({period, valid, locked, timeout} !== {m_period, m_valid, m_locked, m_timeout}) begin
        n_bad++; $display("FAIL timeout_pre t=%0d got %s want %s", t, got_s(), want_s());
      end
    end
    for (int j = 1; j <= 50; j++) begin
      step(0, 0);
      n_cmp++;
      if ({period, valid, locked, timeout} !== {m_period, m_valid, m_locked, m_timeout}) begin
        n_bad++; $display("FAIL timeout_wait t=%0d got %s want %s", t, got_s(), want_s());
      end
      if (j >= 49) begin
        n_cmp++;
        if (timeout !== (j == 50) || locked !== 1'b0 || period !== 16'd12) begin
          n_bad++; $display("FAIL timeout_flag j=%0d got %s want p=12 l=0 to=%0b", j, got_s(), j == 50);
        end
      end
    end
    step(1, 0);
    n_cmp++;
    if (valid !== 1'b0 || timeout !== 1'b1) begin
      n_bad++; $display("FAIL timeout_rearm got %s want v=0 to=1", got_s());
    end
    for (int k = 1; k <= 20; k++) begin
      step(k == 20, 0);
      n_cmp++;
      if ({period, valid, locked, timeout} !== {m_period, m_valid, m_locked, m_timeout}) begin
        n_bad++; $display("FAIL timeout_recover t=%0d got %s want %s", t, got_s(), want_s());
      end
    end
    n_cmp++;
    if (valid !== 1'b1 || period !== 16'd20 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL timeout_clear got %s want v=1 p=20 to=0", got_s());
    end
  endtask

  task automatic test_boundary();
    int nv = 0;
    step(0, 1);
    for (int i = 0; i <= 200; i++) begin
      step((i % TO) == 0, 0);
      n_cmp++;
      if ({period, valid, locked, timeout} !== {m_period, m_valid, m_locked, m_timeout}) begin
        n_bad++; $display("FAIL boundary t=%0d got %s want %s", t, got_s(), want_s());
      end
      n_cmp++;
      if (timeout !== 1'b0 || (valid === 1'b1 && period !== 16'(TO))) begin
        n_bad++; $display("FAIL boundary_rule t=%0d got %s want p=%0d to=0", t, got_s(), TO);
      end
      if (valid === 1'b1) nv++;
    end
    n_cmp++;
    if (nv != 4) begin
      n_bad++; $display("FAIL boundary_count got %0d valids want 4", nv);
    end
  endtask

  task automatic test_respace();
    int nv = 0;
    step(0, 1);
    for (int i = 0; i <= 48; i++) begin
      step((i % 12) == 0, 0);
      n_cmp++;
      if ({period, valid, locked, timeout} !== {m_period, m_valid, m_locked, m_timeout}) begin
        n_bad++; $display("FAIL respace12 t=%0d got %s want %s", t, got_s(), want_s());
      end
    end
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++; $display("FAIL respace_lock12 got l=%0b want 1", locked);
    end
    for (int k = 1; k <= 24; k++) begin
      step((k % 8) == 0, 0);
      n_cmp++;
      if ({period, valid, locked, timeout} !== {m_period, m_valid, m_locked, m_timeout}) begin
        n_bad++; $display("FAIL respace8 t=%0d got %s want %s", t, got_s(), want_s());
      end
      if (valid === 1'b1) begin
        nv++;
        n_cmp++;
        if (period !== 16'd8 || locked !== (nv >= 3)) begin
          n_bad++; $display("FAIL respace8_valid n=%0d got %s want p=8 l=%0b", nv, got_s(), nv >= 3);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(0, 1);
    for (int i = 0; i <= 36; i++) begin
      step((i % 12) == 0, 0);
    end
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_lock got l=%0b want 1", locked);
    end
    for (int i = 0; i < 4; i++) step(0, 0);
    step(1, 1);
    n_cmp++;
    if ({period, valid, locked, timeout} !== {(W+3){1'b0}}) begin
      n_bad++; $display("FAIL rstmid_zero got %s want all zero", got_s());
    end
    for (int k = 1; k <= 7; k++) begin
      step(k == 7, 0);
      n_cmp++;
      if (valid !== 1'b0) begin
        n_bad++; $display("FAIL rstmid_arm k=%0d got %s want v=0", k, got_s());
      end
    end
    for (int k = 1; k <= 9; k++) begin
      step(k == 9, 0);
      n_cmp++;
      if ({period, valid, locked, timeout} !== {m_period, m_valid, m_locked, m_timeout}) begin
        n_bad++; $display("FAIL rstmid_model t=%0d got %s want %s", t, got_s(), want_s());
      end
    end
    n_cmp++;
    if (valid !== 1'b1 || period !== 16'd9) begin
      n_bad++; $display("FAIL rstmid_gap got %s want v=1 p=9", got_s());
    end
  endtask

  task automatic test_random();
    int g;
    step(0, 1);
    for (int n = 0; n < 40; n++) begin
      g = $urandom_range(1, 60);
      for (int k = 1; k <= g; k++) begin
        step(k == g, $urandom_range(0, 99) == 0);
        n_cmp++;
        if ({period, valid, locked, timeout} !== {m_period, m_valid, m_locked, m_timeout}) begin
          n_bad++; $display("FAIL random t=%0d got %s want %s", t, got_s(), want_s());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady12();
    test_const_high();
    test_timeout();
    test_boundary();
    test_respace();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 The module SHALL have parameter W, default 16, giving the width of the period counter and output.
REQ-002 The module SHALL have parameter TIMEOUT, default 1000, giving the longest valid period in clk cycles; legal range 2 to 2^W-1.
REQ-003 The module SHALL have parameter LOCK_N, default 3, giving the number of consecutive identical periods required for lock; legal range 2 to 15.
REQ-004 clk  input  1  system clock; all logic SHALL be on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ce_in  input  1  pulse stream under measurement (e.g. a clock-enable tick), synchronous to clk, sampled every edge.
REQ-007 period  output  W  last measured period in clk cycles.
REQ-008 valid  output  1  one-cycle strobe marking a new period value.
REQ-009 locked  output  1  high while the last LOCK_N periods were identical.
REQ-010 timeout  output  1  sticky flag: no pulse arrived within TIMEOUT cycles.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE (waiting for the first pulse) and MEASURE (counting cycles since the last pulse).
REQ-012 IDLE: ce_in=1 at an edge SHALL move the FSM to MEASURE and set cnt to 1; no valid strobe.
REQ-013 MEASURE, ce_in=1 at an edge SHALL load period with cnt, pulse valid high for the following cycle, and reset cnt to 1; pulses k cycles apart SHALL give period=k.
REQ-014 MEASURE, ce_in=0 with cnt<TIMEOUT SHALL increment cnt by 1.
REQ-015 MEASURE, ce_in=0 with cnt==TIMEOUT SHALL enter IDLE, set timeout=1, clear locked and the match count, and leave period unchanged.
REQ-016 Boundary: ce_in=1 with cnt==TIMEOUT SHALL count as a valid measurement (period=TIMEOUT), not a timeout.
REQ-017 ce_in held continuously high SHALL give period=1 with valid on every cycle after the first pulse.
REQ-018 cnt SHALL never wrap, because TIMEOUT<=2^W-1 caps it.
REQ-019 timeout SHALL clear on the next valid strobe, and SHALL remain set while IDLE otherwise.
REQ-020 The match count SHALL update on each valid strobe: 1 for the first measurement after IDLE or reset; previous+1 (saturating at LOCK_N) when the new period equals the previous period; otherwise 1.
REQ-021 locked SHALL equal (match==LOCK_N) and SHALL update in the same cycle as valid.
REQ-022 valid SHALL be low in every cycle not directly following a measuring edge.

Reset
REQ-023 rst=1 at an edge SHALL force state=IDLE, cnt=0, period=0, valid=0, locked=0, timeout=0 and match=0.
REQ-024 rst SHALL take priority over ce_in in the same cycle; that pulse SHALL be ignored and not count as a first pulse.
REQ-025 A reset mid-measurement SHALL discard the partial count; the first pulse after reset SHALL only arm the FSM.

Verification
REQ-026 The bench SHALL drive ce_in from clk_en with MAX=12, 10 ns clk, and rst for 2 cycles -> valid every 12 cycles with period=12; locked=1 at the 3rd valid; timeout=0 throughout.
REQ-027 The bench SHALL hold ce_in constantly high after reset -> from the 2nd edge onward, valid=1 every cycle with period=1; locked=1 from the 3rd valid.
REQ-028 The bench SHALL set TIMEOUT=50, send 3 pulses spaced 12, then stop -> 50 cycles after the last pulse timeout=1, locked=0 and period stays 12; the next two pulses spaced 20 give valid with period=20 and timeout=0.
REQ-029 The bench SHALL set TIMEOUT=50 and space pulses exactly 50 cycles apart -> period=50 with valid each time and timeout never set.
REQ-030 The bench SHALL reach lock at period 12, then switch the spacing to 8 -> first valid gives period=8 and locked=0; locked=1 again at the 3rd consecutive period of 8.
REQ-031 The bench SHALL assert rst for one cycle 5 cycles after a pulse while locked, with ce_in=1 in that same cycle -> all outputs 0; the next pulse produces no valid; the following pulse gives valid with period equal to the gap between them.
